unified_mem_ctrl: RTL and testbench
===================================

// Module: unified_mem_ctrl
// PURPOSE
//  Single-port memory controller for the one-memory ARM core. Arbitrates instruction fetch
//  (PC) and data access (ALUResult/WriteData) onto one shared synchronous RAM.
//  Returns fetched words to Instr and load data to the datapath ReadData path.
//  Drives a stall that freezes PC and register writes while an access is in flight.
// PARAMETERS
//  AW       32  address width (byte address)
//  DW       32  data width
//  MEM_LAT  1   RAM read latency in cycles; legal range 1..4
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  if_req     in   1   fetch request; level, held until if_valid
//  if_addr    in   AW  fetch byte address (PC)
//  if_rdata   out  DW  fetched instruction; held until next fetch capture
//  if_valid   out  1   one-cycle pulse: if_rdata updated
//  d_req      in   1   data request; level, held until d_valid
//  d_we       in   1   1 = store, 0 = load
//  d_addr     in   AW  data byte address (ALUResult)
//  d_wdata    in   DW  store data (WriteData)
//  d_rdata    out  DW  load data; held until next load capture
//  d_valid    out  1   one-cycle pulse: load data ready or store done
//  stall      out  1   (if_req & ~if_valid) | (d_req & ~d_valid); combinational
//  mem_en     out  1   RAM enable, registered
//  mem_we     out  1   RAM write enable, registered
//  mem_addr   out  AW  RAM byte address, bits [1:0] forced 0
//  mem_wdata  out  DW  RAM write data, registered
//  mem_rdata  in   DW  RAM read data, valid MEM_LAT cycles after the mem_en cycle
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, cnt=0. mem_en, mem_we, if_valid, d_valid = 0.
//    mem_addr, mem_wdata, if_rdata, d_rdata = 0.
//  - States: IDLE, ISSUE, WAIT, DONE. Owner register src records I or D.
//  - IDLE: if d_req, accept data; else if if_req, accept fetch; else stay.
//    Data has priority because it belongs to the current instruction.
//    On accept, latch addr/we/wdata and src, then go to ISSUE.
//  - ISSUE (1 cycle): mem_en=1, mem_we=d_we&(src==D), mem_addr={addr[AW-1:2],2'b00}.
//    A store goes to DONE. A load or fetch sets cnt=MEM_LAT and goes to WAIT.
//  - WAIT: mem_en=0. cnt decrements each cycle. When cnt==1, capture mem_rdata into
//    if_rdata or d_rdata by src, then go to DONE.
//    cnt is $clog2(MEM_LAT+1) bits wide and never wraps below 0.
//  - DONE (1 cycle): pulse if_valid or d_valid by src, return to IDLE.
//    Requests are never sampled in DONE.
//  - Latency from accept edge to valid cycle: load/fetch = MEM_LAT+2 cycles, store = 2 cycles.
//    Next accept is possible on the cycle after DONE.
//  - If req drops mid-transaction, the transaction still completes and valid still pulses.
//    The result is discarded by the core.
//  - Request inputs are ignored outside IDLE. A new d_req never preempts an active fetch.
//  - Reset asserted mid-transaction aborts it. Outputs clear immediately.
//    Later-arriving mem_rdata is never captured, and no valid pulse follows reset release.
//  - Never more than one RAM access outstanding.
// TESTING
//  1. MEM_LAT=1, RAM[0x10]=0xE3A00005, if_req, if_addr=0x10 at cycle 0:
//     mem_en=1 and mem_addr=0x10 in cycle 1; if_valid=1 and if_rdata=0xE3A00005 in cycle 3.
//     stall=1 in cycles 0-2.
//  2. MEM_LAT=1, d_req (load 0x100) and if_req (0x14) both asserted at cycle 0:
//     data served first, d_valid in cycle 3; fetch accepted cycle 4, if_valid in cycle 7.
//  3. Store 0xDEADBEEF to 0x200: mem_we=1 for exactly one cycle (cycle 1), d_valid in cycle 2.
//     A following load of 0x200 returns 0xDEADBEEF.
//  4. MEM_LAT=3, fetch: if_valid in cycle 5. stall stays high in cycles 0-4.
//     mem_en is high only in cycle 1.
//  5. Reset pulsed low during WAIT: all outputs 0 at once. RAM data arriving after release
//     is ignored and no valid pulses. A new if_req after release completes normally.
//  6. d_addr=0x13 load -> mem_addr=0x10.
//     if_req held through DONE is not re-accepted until the cycle after DONE.

Source files
------------

// File: rtl/unified_mem_ctrl.sv
// Single-port RAM controller shared by instruction fetch and data access.
// One access in flight at a time; data requests win arbitration in IDLE.
module unified_mem_ctrl #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic            src_q, src_d;   // 1 = data port owns the access
  logic            we_q, we_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            if_valid_q, if_valid_d;
  logic            d_valid_q, d_valid_d;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // RAM strobes are registered, so they are loaded on the accept edge
        if (d_req) begin
          src_d       = 1'b1;
          we_d        = d_we;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = {d_addr[AW-1:2], 2'b00};
          mem_wdata_d = d_wdata;
          state_d     = ISSUE;
        end else if (if_req) begin
          src_d      = 1'b0;
          we_d       = 1'b0;
          mem_en_d   = 1'b1;
          mem_addr_d = {if_addr[AW-1:2], 2'b00};
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (src_q && we_q) begin
          d_valid_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d   = CW'(MEM_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          if (src_q) begin
            d_rdata_d = mem_rdata;
            d_valid_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      src_q       <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign stall     = (if_req & ~if_valid_q) | (d_req & ~d_valid_q);

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Bench for unified_mem_ctrl: MEM_LAT=1 instance with scoreboard and vector table,
// MEM_LAT=3 instance for latency and mid-transaction reset sequences.
module tb_unified_mem_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // MEM_LAT = 1 instance
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, d_valid, stall, mem_en, mem_we;
  // MEM_LAT = 3 instance
  logic        if_req3, d_req3, d_we3;
  logic [31:0] if_addr3, d_addr3, d_wdata3, mem_rdata3;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3;
  logic        if_valid3, d_valid3, stall3, mem_en3, mem_we3;

  unified_mem_ctrl #(.AW(32), .DW(32), .MEM_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .stall(stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  unified_mem_ctrl #(.AW(32), .DW(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_valid(if_valid3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_rdata(d_rdata3), .d_valid(d_valid3), .stall(stall3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  // RAM model: fixed initial image plus a write overlay; reads use the full byte
  // address so a misaligned mem_addr returns the wrong word.
  logic [31:0] wr_data [0:1023];
  bit          wr_vld  [0:1023];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [0:2];

  function automatic logic [31:0] mem_init(logic [31:0] a);
    case (a)
      32'h10:  return 32'hE3A00005;
      32'h14:  return 32'hE2811001;
      32'h20:  return 32'hA5A50020;
      32'h100: return 32'h11112222;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  function automatic logic [31:0] rd_word(logic [31:0] a);
    return wr_vld[a[11:2]] ? wr_data[a[11:2]] : mem_init(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wr_vld[mem_addr[11:2]]  <= 1'b1;
      wr_data[mem_addr[11:2]] <= mem_wdata;
    end
    pipe1    <= (mem_en && !mem_we) ? rd_word(mem_addr) : 32'h5A5A5A5A;
    pipe3[0] <= mem_en3 ? rd_word(mem_addr3) : 32'h5A5A5A5A;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_rdata  = pipe1;
  assign mem_rdata3 = pipe3[2];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(string name, logic act, logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Scoreboard: entries pushed when a request is driven, popped on valid pulses
  typedef struct {
    bit          is_d;
    bit          chk_data;
    logic [31:0] rdata;
    int          cyc0;
    int          lat;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (reset && (if_valid || d_valid)) begin
      if (sb.size() == 0) begin
        check1("unexpected_valid", 1'b1, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check1("valid_src", d_valid, mon_e.is_d);
        check("valid_latency", 32'(cyc - mon_e.cyc0), 32'(mon_e.lat));
        if (mon_e.chk_data)
          check(mon_e.is_d ? "d_rdata" : "if_rdata", mon_e.is_d ? d_rdata : if_rdata, mon_e.rdata);
        $display("txn %s rdata=%h latency=%0d cycle=%0d", mon_e.is_d ? "D" : "I",
                 mon_e.is_d ? d_rdata : if_rdata, cyc - mon_e.cyc0, cyc);
      end
    end
  end

  task automatic start_req(bit is_d, bit we, logic [31:0] addr, logic [31:0] wdata,
                           logic [31:0] exp, int lat);
    exp_t e;
    e.is_d = is_d; e.chk_data = !(is_d && we); e.rdata = exp; e.cyc0 = cyc; e.lat = lat;
    if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else begin if_req = 1'b1; if_addr = addr; end
    sb.push_back(e);
  endtask

  task automatic wait_valid(bit is_d);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = is_d ? d_valid : if_valid;
    end
    if (!seen) check1("valid_timeout", 1'b0, 1'b1);
    else check1("mem_we_at_valid", mem_we, 1'b0);
    @(posedge clk); #1;
    if (is_d) d_req = 1'b0; else if_req = 1'b0;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_maddr;
    int          lat;
  } vec_t;
  vec_t vt [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 32'h0,        32'h200, 2};
    vt[1] = '{1'b1, 1'b0, 32'h200, 32'h0,        32'hDEADBEEF, 32'h200, 3};
    vt[2] = '{1'b1, 1'b0, 32'h13,  32'h0,        32'hE3A00005, 32'h10,  3};
    vt[3] = '{1'b1, 1'b1, 32'h204, 32'h12345678, 32'h0,        32'h204, 2};
    vt[4] = '{1'b0, 1'b0, 32'h204, 32'h0,        32'h12345678, 32'h204, 3};
    vt[5] = '{1'b0, 1'b0, 32'h23,  32'h0,        32'hA5A50020, 32'h20,  3};
    vt[6] = '{1'b1, 1'b0, 32'h7C,  32'h0,        32'hC0DE007C, 32'h7C,  3};

    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    if_req3 = 0; d_req3 = 0; d_we3 = 0; if_addr3 = 0; d_addr3 = 0; d_wdata3 = 0;

    // Reset state
    #1;
    check1("rst_mem_en", mem_en, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check1("rst_if_valid", if_valid, 1'b0);
    check1("rst_d_valid", d_valid, 1'b0);
    check1("rst_stall", stall, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Basic fetch, cycle by cycle
    @(posedge clk); #1;
    start_req(1'b0, 1'b0, 32'h10, 32'h0, 32'hE3A00005, 3);
    @(negedge clk);
    check1("t1_c0_stall", stall, 1'b1);
    check1("t1_c0_mem_en", mem_en, 1'b0);
    @(negedge clk);
    check1("t1_c1_stall", stall, 1'b1);
    check1("t1_c1_mem_en", mem_en, 1'b1);
    check("t1_c1_mem_addr", mem_addr, 32'h10);
    @(negedge clk);
    check1("t1_c2_stall", stall, 1'b1);
    check1("t1_c2_mem_en", mem_en, 1'b0);
    wait_valid(1'b0);

    // Simultaneous requests: data first, fetch accepted after DONE
    @(posedge clk); #1;
    start_req(1'b1, 1'b0, 32'h100, 32'h0, 32'h11112222, 3);
    start_req(1'b0, 1'b0, 32'h14,  32'h0, 32'hE2811001, 7);
    wait_valid(1'b1);
    wait_valid(1'b0);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      start_req(vt[i].is_d, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_rdata, vt[i].lat);
      @(negedge clk);
      check1($sformatf("v%0d_c0_mem_en", i), mem_en, 1'b0);
      @(negedge clk);
      check1($sformatf("v%0d_c1_mem_en", i), mem_en, 1'b1);
      check1($sformatf("v%0d_c1_mem_we", i), mem_we, vt[i].is_d & vt[i].we);
      check($sformatf("v%0d_c1_mem_addr", i), mem_addr, vt[i].exp_maddr);
      if (vt[i].we) check($sformatf("v%0d_c1_mem_wdata", i), mem_wdata, vt[i].wdata);
      wait_valid(vt[i].is_d);
    end

    // Fetch request held through DONE: re-accepted only after the IDLE cycle
    @(posedge clk); #1;
    start_req(1'b0, 1'b0, 32'h20, 32'h0, 32'hA5A50020, 3);
    for (int k = 0; k < 20 && !if_valid; k++) @(negedge clk);
    check1("t6_first_valid", if_valid, 1'b1);
    sb.push_back('{1'b0, 1'b1, 32'hA5A50020, cyc + 1, 3});
    @(negedge clk);
    check1("t6_idle_mem_en", mem_en, 1'b0);
    check1("t6_idle_stall", stall, 1'b1);
    @(negedge clk);
    check1("t6_reaccept_mem_en", mem_en, 1'b1);
    wait_valid(1'b0);

    // MEM_LAT=3 fetch timing
    @(posedge clk); #1;
    if_req3 = 1'b1; if_addr3 = 32'h14;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check1($sformatf("t4_c%0d_stall", k), stall3, k <= 4);
      check1($sformatf("t4_c%0d_mem_en", k), mem_en3, k == 1);
      check1($sformatf("t4_c%0d_if_valid", k), if_valid3, k == 5);
    end
    check("t4_if_rdata", if_rdata3, 32'hE2811001);
    $display("txn L3 fetch rdata=%h", if_rdata3);
    @(posedge clk); #1;
    if_req3 = 1'b0;

    // Reset asserted during WAIT on the MEM_LAT=3 instance
    @(posedge clk); #1;
    if_req3 = 1'b1; if_addr3 = 32'h10;
    repeat (3) @(negedge clk);
    reset = 1'b0; if_req3 = 1'b0;
    #1;
    check1("t5_mem_en", mem_en3, 1'b0);
    check1("t5_mem_we", mem_we3, 1'b0);
    check("t5_mem_addr", mem_addr3, 32'h0);
    check("t5_mem_wdata", mem_wdata3, 32'h0);
    check("t5_if_rdata", if_rdata3, 32'h0);
    check("t5_d_rdata", d_rdata3, 32'h0);
    check1("t5_if_valid", if_valid3, 1'b0);
    check1("t5_d_valid", d_valid3, 1'b0);
    check1("t5_stall", stall3, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check1($sformatf("t5_post_%0d_if_valid", k), if_valid3, 1'b0);
      check1($sformatf("t5_post_%0d_mem_en", k), mem_en3, 1'b0);
    end
    check("t5_no_capture", if_rdata3, 32'h0);
    $display("txn L3 reset-abort if_rdata=%h", if_rdata3);

    // Fresh fetch after reset release completes normally
    @(posedge clk); #1;
    if_req3 = 1'b1; if_addr3 = 32'h10;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check1($sformatf("t5_new_c%0d_if_valid", k), if_valid3, k == 5);
    end
    check("t5_new_if_rdata", if_rdata3, 32'hE3A00005);
    $display("txn L3 post-reset fetch rdata=%h", if_rdata3);
    @(posedge clk); #1;
    if_req3 = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
